// File: rtl/debounce_pkg.sv
// ---------------------------------------------------------------------------
// debounce_pkg : state encoding and default stability length for debounce_edge_det
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package debounce_pkg;

  localparam logic [1:0] ST_STABLE_LO = 2'b00;
  localparam logic [1:0] ST_WAIT_HI   = 2'b01;
  localparam logic [1:0] ST_STABLE_HI = 2'b11;
  localparam logic [1:0] ST_WAIT_LO   = 2'b10;

  localparam int DEFAULT_STABLE_CYCLES = 4;

endpackage

`default_nettype wire

// File: rtl/debounce_edge_det.sv
// ---------------------------------------------------------------------------
// debounce_edge_det : debounces a synchronous 1-bit level, emits rise/fall pulses
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module debounce_edge_det
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  generate
    if (STABLE_CYCLES < 2) begin : g_param_check
      $fatal(1, "debounce_edge_det: STABLE_CYCLES must be at least 2");
    end
  endgenerate

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             q_nxt, rise_nxt, fall_nxt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    q_nxt     = q;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    if (en) begin
      case (state)
        ST_STABLE_LO: begin
          if (d) begin
            state_nxt = ST_WAIT_HI;
            cnt_nxt   = CNT_ONE;
          end
        end
        ST_WAIT_HI: begin
          if (!d) begin
            state_nxt = ST_STABLE_LO;
            cnt_nxt   = '0;
          end else if (cnt == CNT_MAX) begin
            state_nxt = ST_STABLE_HI;
            cnt_nxt   = '0;
            q_nxt     = 1'b1;
            rise_nxt  = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        ST_STABLE_HI: begin
          if (!d) begin
            state_nxt = ST_WAIT_LO;
            cnt_nxt   = CNT_ONE;
          end
        end
        ST_WAIT_LO: begin
          // A high sample while waiting to fall means the low was a glitch.
          if (d) begin
            state_nxt = ST_STABLE_HI;
            cnt_nxt   = '0;
          end else if (cnt == CNT_MAX) begin
            state_nxt = ST_STABLE_LO;
            cnt_nxt   = '0;
            q_nxt     = 1'b0;
            fall_nxt  = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        default: begin
          state_nxt = ST_STABLE_LO;
          cnt_nxt   = '0;
          q_nxt     = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_STABLE_LO;
      cnt   <= '0;
      q     <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      q     <= q_nxt;
      rise  <= rise_nxt;
      fall  <= fall_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_debounce_edge_det.sv
// ---------------------------------------------------------------------------
// tb_debounce_edge_det : directed and randomized checks of debounce_edge_det
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_debounce_edge_det;
  import debounce_pkg::*;

  localparam int N = DEFAULT_STABLE_CYCLES;

  logic clk, rst, en, d;
  logic q, rise, fall;

  int tests = 0;
  int fails = 0;

  debounce_edge_det #(.STABLE_CYCLES(N)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .d    (d),
    .q    (q),
    .rise (rise),
    .fall (fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: q flips once N consecutive enabled samples disagree with it.
  logic m_q, m_rise, m_fall;
  int   m_run;
  always @(posedge clk) begin
    if (rst) begin
      m_q <= 1'b0; m_run <= 0; m_rise <= 1'b0; m_fall <= 1'b0;
    end else begin
      m_rise <= 1'b0;
      m_fall <= 1'b0;
      if (en) begin
        if (d != m_q) begin
          if (m_run + 1 == N) begin
            m_q <= d; m_run <= 0; m_rise <= d; m_fall <= ~d;
          end else begin
            m_run <= m_run + 1;
          end
        end else begin
          m_run <= 0;
        end
      end
    end
  end

  // Cycle-by-cycle invariants on the DUT outputs.
  logic rst_last, q_prev;
  always @(posedge clk) rst_last <= rst;
  always @(negedge clk) begin
    if (rst_last === 1'b0) begin
      tests++;
      if ((rise & fall) !== 1'b0) begin
        fails++;
        $display("FAIL both_pulses: rise=%b fall=%b required not both 1", rise, fall);
      end
      tests++;
      if (q !== q_prev && !(rise | fall)) begin
        fails++;
        $display("FAIL q_without_pulse: q %b->%b with rise=%b fall=%b", q_prev, q, rise, fall);
      end
    end
    q_prev = q;
  end

  task automatic step(input logic r, input logic e, input logic dv);
    @(negedge clk);
    rst = r; en = e; d = dv;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    tests++;
    if ({q, rise, fall} !== 3'b000) begin
      fails++;
      $display("FAIL reset_outputs: q/rise/fall=%b required 000", {q, rise, fall});
    end
    for (int i = 0; i < N; i++) begin
      step(1'b0, 1'b1, 1'b1);
      tests++;
      if (q !== (i == N - 1)) begin
        fails++;
        $display("FAIL reset_release_q: sample %0d q=%b required %b", i, q, (i == N - 1));
      end
    end
  endtask

  task automatic test_rise();
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i <= N; i++) begin
      step(1'b0, 1'b1, 1'b1);
      tests++;
      if ({q, rise, fall} !== {(i >= N - 1), (i == N - 1), 1'b0}) begin
        fails++;
        $display("FAIL rise_seq: edge %0d q/rise/fall=%b required %b", i, {q, rise, fall},
                 {(i >= N - 1), (i == N - 1), 1'b0});
      end
    end
  endtask

  task automatic test_glitch();
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < N; i++) begin
      step(1'b0, 1'b1, (i < N - 1));
      tests++;
      if ({q, rise} !== 2'b00) begin
        fails++;
        $display("FAIL glitch_reject: edge %0d q/rise=%b required 00", i, {q, rise});
      end
    end
    for (int i = 0; i < N; i++) step(1'b0, 1'b1, 1'b1);
    tests++;
    if ({q, rise} !== 2'b11) begin
      fails++;
      $display("FAIL glitch_recover: q/rise=%b required 11", {q, rise});
    end
  endtask

  task automatic test_fall();
    logic [4:0] pat;
    pat = 5'b10010;  // applied LSB first: 0 1 0 0 1
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < N; i++) step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, pat[i]);
      tests++;
      if ({q, fall} !== 2'b10) begin
        fails++;
        $display("FAIL fall_glitch: edge %0d q/fall=%b required 10", i, {q, fall});
      end
    end
    for (int i = 0; i <= N; i++) begin
      step(1'b0, 1'b1, 1'b0);
      tests++;
      if ({q, fall, rise} !== {(i < N - 1), (i == N - 1), 1'b0}) begin
        fails++;
        $display("FAIL fall_seq: edge %0d q/fall/rise=%b required %b", i, {q, fall, rise},
                 {(i < N - 1), (i == N - 1), 1'b0});
      end
    end
  endtask

  task automatic test_enable();
    int en_cnt = 0;
    step(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 2 * N; k++) begin
      step(1'b0, (k % 2 == 0), 1'b1);
      if (k % 2 == 0) en_cnt++;
      tests++;
      if ({q, rise} !== {(en_cnt >= N), (en_cnt == N && k % 2 == 0)}) begin
        fails++;
        $display("FAIL enable_gap: clk %0d q/rise=%b required %b", k, {q, rise},
                 {(en_cnt >= N), (en_cnt == N && k % 2 == 0)});
      end
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    tests++;
    if (q !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_hold: q=%b required 0", q);
    end
    for (int i = 0; i < N; i++) begin
      step(1'b0, 1'b1, 1'b1);
      tests++;
      if ({q, rise} !== {(i == N - 1), (i == N - 1)}) begin
        fails++;
        $display("FAIL reset_mid_restart: edge %0d q/rise=%b required %b", i, {q, rise},
                 {(i == N - 1), (i == N - 1)});
      end
    end
  endtask

  task automatic test_random();
    logic dv = 1'b0;
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 5) == 0) dv = ~dv;
      step(1'b0, ($urandom_range(0, 3) != 0), dv);
      tests++;
      if ({q, rise, fall} !== {m_q, m_rise, m_fall}) begin
        fails++;
        $display("FAIL random_model: cycle %0d q/rise/fall=%b required %b", i,
                 {q, rise, fall}, {m_q, m_rise, m_fall});
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; d = 1'b0;
    test_reset();
    test_rise();
    test_glitch();
    test_fall();
    test_enable();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
